spi_peripheral_xcvr: RTL and testbench

- SPI mode-0 responder (peripheral end) that sits behind the SPI pad cells and faces an external SPI initiator.
- Oversamples sclk, cs_n and copi in the system clock domain, then deserializes received frames.
- Serializes transmit frames onto cipo from a one-deep holding buffer.
- Presents a valid/ready TX interface and a strobe-only RX interface to fabric logic.

---
 rtl/spi_periph_pkg.sv | 23 ++
 rtl/spi_pin_sync.sv | 38 +++
 rtl/spi_peripheral_xcvr.sv | 197 +++++++++++++++++++
 tb/tb_spi_peripheral_xcvr.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_periph_pkg.sv
// Shared types and helpers for the SPI peripheral transceiver.
package spi_periph_pkg;

   // Transceiver state: deselected or inside a chip-select window
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // Default word shifted out when nothing is buffered; sliced to WIDTH by the user
   localparam logic [31:0] IDLE_WORD_DEFAULT = '1;

   // Bits needed to count 0..value-1 (at least one bit)
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer for one asynchronous SPI pad input, with registered edge pulses.
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise_q;
   logic                   fall_q;

   // Synchronizer chain, history flop and single-cycle edge pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_LEVEL}};
         hist_q <= RST_LEVEL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         hist_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/spi_peripheral_xcvr.sv
// SPI mode-0 peripheral transceiver: oversampled pad inputs, one-deep TX buffer,
// MSB-first shift in/out, back-to-back frames within one chip-select window.
// Optional: define SPI_PERIPH_CIPO_TRISTATE_EN to release cipo_oe while deselected.
module spi_peripheral_xcvr
   import spi_periph_pkg::*;
#(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0]  IDLE_WORD   = IDLE_WORD_DEFAULT[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             copi,
   output logic             cipo,
   output logic             cipo_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             tx_underrun
);

   localparam int unsigned CW = clog2(WIDTH);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic copi_s, copi_rise, copi_fall;
   logic unused_sync_outputs;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-2:0]   rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0]   rx_word_c;
   logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0]   buf_q, buf_d;
   logic               buf_empty_q, buf_empty_d;
   logic [WIDTH-1:0]   rx_data_q, rx_data_d;
   logic               rx_done_q, rx_done_d;
   logic               rx_valid_q, rx_valid_d;
   logic               underrun_q, underrun_d;
   logic               busy_q, busy_d;
   logic               cipo_oe_q, cipo_oe_d;
   logic               load_c;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst   (rst),
      .pin   (sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_sync_cs (
      .clk   (clk),
      .rst   (rst),
      .pin   (cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_copi (
      .clk   (clk),
      .rst   (rst),
      .pin   (copi),
      .level (copi_s),
      .rise  (copi_rise),
      .fall  (copi_fall)
   );

   // Edges of copi and the raw sclk level carry no meaning for this block
   assign unused_sync_outputs = ^{sclk_level, copi_rise, copi_fall};

   // Receive word as it stands once the current copi bit is shifted in
   assign rx_word_c = {rx_shift_q, copi_s};

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '1;
         buf_q       <= '0;
         buf_empty_q <= 1'b1;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         busy_q      <= 1'b0;
         cipo_oe_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         buf_q       <= buf_d;
         buf_empty_q <= buf_empty_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
         cipo_oe_q   <= cipo_oe_d;
      end
   end

   // Next-state, shifter, holding-buffer and strobe logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      buf_d       = buf_q;
      buf_empty_d = buf_empty_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      rx_valid_d  = rx_done_q;
      underrun_d  = 1'b0;
      busy_d      = ~cs_level;
`ifdef SPI_PERIPH_CIPO_TRISTATE_EN
      cipo_oe_d   = ~cs_level;
`else
      cipo_oe_d   = 1'b1;
`endif
      load_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
               load_c  = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               // Deselect wins over any sclk edge; partial words are dropped
               state_d    = ST_IDLE;
               cnt_d      = '0;
               rx_shift_d = '0;
               tx_shift_d = '1;
            end else if (sclk_rise) begin
               rx_shift_d = rx_word_c[WIDTH-2:0];
               if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_d     = '0;
                  rx_data_d = rx_word_c;
                  rx_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (sclk_fall) begin
               if (cnt_q != '0) begin
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b1};
               end else begin
                  // Frame boundary inside one select window: next word, no gap
                  load_c = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Shifter load takes the buffered word, or the idle word on underrun
      if (load_c) begin
         if (!buf_empty_q) begin
            tx_shift_d = buf_q;
         end else begin
            tx_shift_d = IDLE_WORD;
            underrun_d = 1'b1;
         end
         buf_empty_d = 1'b1;
      end

      // Capture happens after the load so a same-cycle offer is kept
      if (tx_valid && buf_empty_q) begin
         buf_d       = tx_data;
         buf_empty_d = 1'b0;
      end
   end

   assign cipo        = tx_shift_q[WIDTH-1];
   assign cipo_oe     = cipo_oe_q;
   assign tx_ready    = buf_empty_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;
   assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral_xcvr.sv
// Directed testbench for spi_peripheral_xcvr acting as the SPI initiator.
module tb_spi_peripheral_xcvr;

   localparam int unsigned W    = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned HALF = 4;

   typedef struct {
      logic [W-1:0] d;
      int           due;
   } rx_exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         sclk, cs_n, copi;
   logic         cipo, cipo_oe;
   logic [W-1:0] tx_data;
   logic         tx_valid, tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid, busy, tx_underrun;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           under_seen = 0;
   int           exp_under = 0;

   logic [W-1:0] buf_model[$];
   rx_exp_t      exp_q[$];
   logic [W-1:0] cur_word;
   logic [W-1:0] rx_acc;
   int           bit_idx;
   logic         idle_oe;

   spi_peripheral_xcvr #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .copi        (copi),
      .cipo        (cipo),
      .cipo_oe     (cipo_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle check of the receive strobe against the model's due times
   always @(negedge clk) begin
      if (tx_underrun === 1'b1) under_seen++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("rx_valid_strobe", {31'd0, rx_valid}, 32'd1);
         chk("rx_data_strobe", {24'd0, rx_data}, {24'd0, exp_q[0].d});
         exp_q.delete(0);
      end else begin
         chk("rx_valid_quiet", {31'd0, rx_valid}, 32'd0);
      end
   end

   // Model: next word the shifter must present at a frame start
   task automatic start_word();
      if (buf_model.size() > 0) begin
         cur_word = buf_model.pop_front();
      end else begin
         cur_word = '1;
         exp_under++;
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      int n;
      n = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready_seen", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      buf_model.push_back(w);
   endtask

   task automatic cs_start();
      cs_n    = 1'b0;
      bit_idx = 0;
      rx_acc  = '0;
      start_word();
      repeat (HALF + 1) @(negedge clk);
   endtask

   // One sclk period: present copi, check cipo before the rise, then fall
   task automatic spi_bit(input logic b, input logic end_cs);
      copi = b;
      repeat (HALF) @(negedge clk);
      chk("cipo_bit", {31'd0, cipo}, {31'd0, cur_word[W-1-bit_idx]});
      chk("cipo_oe_active", {31'd0, cipo_oe}, 32'd1);
      sclk   = 1'b1;
      rx_acc = {rx_acc[W-2:0], b};
      bit_idx++;
      if (bit_idx == W) begin
         exp_q.push_back('{d: rx_acc, due: cyc + SYNC + 3});
      end
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (end_cs) begin
         cs_n    = 1'b1;
         bit_idx = 0;
      end else if (bit_idx == W) begin
         bit_idx = 0;
         start_word();
      end
   endtask

   task automatic run_bits(input logic [W-1:0] w, input int first, input int last, input logic end_cs);
      for (int i = first; i <= last; i++) begin
         spi_bit(w[W-1-i], end_cs && (i == last));
      end
   endtask

   task automatic idle_checks(input string tag);
      repeat (8) @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_cipo"}, {31'd0, cipo}, 32'd1);
      chk({tag, "_cipo_oe"}, {31'd0, cipo_oe}, {31'd0, idle_oe});
      chk({tag, "_underruns"}, 32'(under_seen), 32'(exp_under));
   endtask

   initial begin
`ifdef SPI_PERIPH_CIPO_TRISTATE_EN
      idle_oe = 1'b0;
`else
      idle_oe = 1'b1;
`endif
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
      cur_word = '1; rx_acc = '0; bit_idx = 0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_cipo", {31'd0, cipo}, 32'd1);
      chk("rst_cipo_oe", {31'd0, cipo_oe}, 32'd1);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_underrun", {31'd0, tx_underrun}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_cipo_oe", {31'd0, cipo_oe}, {31'd0, idle_oe});

      // Buffered 0xA5 out, 0x3C in
      push(8'hA5);
      chk("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
      cs_start();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
      run_bits(8'h3C, 0, W - 1, 1'b1);
      idle_checks("t1");
      chk("t1_rx_data_literal", {24'd0, rx_data}, 32'h3C);
      chk("t1_no_underrun", 32'(under_seen), 32'd0);

      // Empty buffer: idle word and one underrun
      cs_start();
      run_bits(8'hC6, 0, W - 1, 1'b1);
      idle_checks("t2");
      chk("t2_rx_data_literal", {24'd0, rx_data}, 32'hC6);
      chk("t2_underrun_literal", 32'(under_seen), 32'd1);

      // Back-to-back frames: 0x12 then 0x34, copi 0x81 then 0x7E
      push(8'h12);
      cs_start();
      spi_bit(1'b1, 1'b0);
      push(8'h34);
      run_bits(8'h81, 1, W - 1, 1'b0);
      run_bits(8'h7E, 0, W - 1, 1'b1);
      idle_checks("t3");
      chk("t3_rx_data_literal", {24'd0, rx_data}, 32'h7E);
      chk("t3_underrun_literal", 32'(under_seen), 32'd1);

      // Deselect after 5 bits, then the buffered word starts from its MSB
      push(8'h96);
      cs_start();
      push(8'hC3);
      run_bits(8'hF0, 0, 4, 1'b1);
      idle_checks("t4");
      chk("t4_rx_data_kept", {24'd0, rx_data}, 32'h7E);
      cs_start();
      chk("t4_first_bit_literal", {31'd0, cipo}, 32'd1);
      run_bits(8'h5A, 0, W - 1, 1'b1);
      idle_checks("t4b");
      chk("t4_rx_data_literal", {24'd0, rx_data}, 32'h5A);

      // Reset after 3 bits, then a normal frame
      push(8'h0F);
      cs_start();
      push(8'hE7);
      run_bits(8'hAA, 0, 2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_cipo", {31'd0, cipo}, 32'd1);
      chk("mid_rst_cipo_oe", {31'd0, cipo_oe}, 32'd1);
      chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_underrun", {31'd0, tx_underrun}, 32'd0);
      rst  = 1'b0;
      cs_n = 1'b1;
      copi = 1'b0;
      buf_model.delete();
      exp_q.delete();
      bit_idx = 0;
      idle_checks("t5");
      push(8'h69);
      cs_start();
      run_bits(8'hB4, 0, W - 1, 1'b1);
      idle_checks("t5b");
      chk("t5_rx_data_literal", {24'd0, rx_data}, 32'hB4);

      repeat (20) @(negedge clk);
      chk("rx_pending_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
